uart_program_loader: RTL and testbench

Serial program loader that sits directly upstream of the byte-wide instruction memory. It receives 8N1 UART bytes on a single rx line and presents each byte on write_Instruction, with a clean write_Ready pulse and a write qualifier. The instruction memory captures on the rising edge of write_Ready and auto-increments its own address. The loader tracks the byte count and stops at the memory size, so the memory counter never wraps.

---
 rtl/uart_program_loader.sv | 158 +++++++++++++++
 tb/tb_uart_program_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// uart_program_loader: UART receiver streaming program bytes into byte-wide instruction memory.
// 8N1 frames by default; define PARITY_EN for 8E1 frames with a sticky parity_error output.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_BYTES    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        load_en,
  output logic [7:0]  write_Instruction,
  output logic        write_Ready,
  output logic        write,
  output logic [10:0] byte_count,
  output logic        load_done,
`ifdef PARITY_EN
  output logic        parity_error,
`endif
  output logic        frame_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP,
    DELIVER
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, wi_n;
  logic [1:0] dcnt, dcnt_n;
  logic [10:0] bc_n;
  logic rx_q, rx_s, bad, bad_n, hold, hold_n, wr_n, done_n, fe_n;
`ifdef PARITY_EN
  logic pe_n;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_s, rx_q} <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      dcnt <= '0;
      bad <= 1'b0;
      hold <= 1'b0;
      write_Instruction <= '0;
      write_Ready <= 1'b0;
      write <= 1'b0;
      byte_count <= '0;
      load_done <= 1'b0;
      frame_error <= 1'b0;
`ifdef PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      {rx_s, rx_q} <= {rx_q, rx};
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      dcnt <= dcnt_n;
      bad <= bad_n;
      hold <= hold_n;
      write_Instruction <= wi_n;
      write_Ready <= wr_n;
      write <= load_en & ~load_done;
      byte_count <= bc_n;
      load_done <= done_n;
      frame_error <= fe_n;
`ifdef PARITY_EN
      parity_error <= pe_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    dcnt_n = dcnt;
    bad_n = bad;
    hold_n = hold;
    wi_n = write_Instruction;
    wr_n = 1'b0;
    bc_n = byte_count;
    done_n = load_done;
    fe_n = frame_error;
`ifdef PARITY_EN
    pe_n = parity_error;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        bad_n = 1'b0;
        hold_n = 1'b0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (cnt == HALF) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n = {rx_s, sh[7:1]};
          idx_n = idx + 3'd1;
`ifdef PARITY_EN
          if (idx == 3'd7) state_n = PARITY;
`else
          if (idx == 3'd7) state_n = STOP;
`endif
        end
`ifdef PARITY_EN
      PARITY:
        if (cnt == LAST) begin
          cnt_n = '0;
          state_n = STOP;
          if (rx_s != ^sh) begin
            bad_n = 1'b1;
            pe_n = 1'b1;
          end
        end
`endif
      STOP:
        if (hold) state_n = rx_s ? IDLE : STOP;
        else if (cnt == LAST) begin
          cnt_n = '0;
          dcnt_n = '0;
          wi_n = (rx_s && load_en && !load_done && !bad) ? sh : write_Instruction;
          state_n = !rx_s ? STOP : (load_en && !load_done && !bad) ? DELIVER : IDLE;
          hold_n = !rx_s;
          fe_n = frame_error | !rx_s;
        end
      DELIVER: begin
        // Track a start bit arriving during delivery so the next frame keeps its timing
        dcnt_n = dcnt + 2'd1;
        cnt_n = rx_s ? '0 : cnt + 1'b1;
        wr_n = dcnt != 2'd2;
        if (dcnt == 2'd2) begin
          cnt_n = rx_s ? '0 : cnt;
          state_n = rx_s ? IDLE : START;
          bc_n = byte_count + 11'd1;
          done_n = (byte_count + 11'd1) == 11'(MAX_BYTES);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: table vectors, corner sequences and randomized frames against a byte-level model.
module tb_uart_program_loader;
  localparam int CPB = 4;
  localparam int MAXB = 4;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, load_en = 1'b1;
  logic [7:0] write_Instruction;
  logic write_Ready, write, load_done, frame_error;
  logic [10:0] byte_count;
`ifdef PARITY_EN
  logic parity_error;
`endif
  int n_cmp = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic par_bad = 1'b0;
  int m_cnt;
  logic m_fe, m_pe = 1'b0;

  always #5 clk = ~clk;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .load_en(load_en),
    .write_Instruction(write_Instruction),
    .write_Ready(write_Ready),
    .write(write),
    .byte_count(byte_count),
    .load_done(load_done),
`ifdef PARITY_EN
    .parity_error(parity_error),
`endif
    .frame_error(frame_error)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic wr_prev = 1'b0;
  logic [7:0] wi_prev = 8'h00;
  int width = 0;
  always @(negedge clk) begin
    if (write_Ready && !wr_prev) begin
      check("setup_data", 32'(wi_prev), 32'(write_Instruction));
      check("write_qual", 32'(write), 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: got byte %0h expected none", write_Instruction);
      end else check("pulse_data", 32'(write_Instruction), 32'(exp_q.pop_front()));
    end
    if (write_Ready) width++;
    else if (wr_prev) begin
      check("pulse_width", 32'(width), 32'd2);
      width = 0;
    end
    wr_prev = write_Ready;
    wi_prev = write_Instruction;
  end

  task automatic bit_period(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    if (PAR) bit_period(^d ^ par_bad);
    bit_period(stop);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle(input logic [10:0] ec, input logic efe, input logic edone);
    repeat (2 * CPB) @(negedge clk);
    check("byte_count", 32'(byte_count), 32'(ec));
    check("frame_error", 32'(frame_error), 32'(efe));
    check("load_done", 32'(load_done), 32'(edone));
    check("write", 32'(write), 32'(load_en & ~edone));
    check("pending_bytes", 32'(exp_q.size()), 32'd0);
`ifdef PARITY_EN
    check("parity_error", 32'(parity_error), 32'(m_pe));
`endif
  endtask

  typedef struct {
    logic rst;
    logic [7:0] d;
    logic stop, en, b2b, dlv;
    logic [10:0] cnt;
    logic fe, done;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic st, en;
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 11'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h37, 1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 11'd4, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 11'd4, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 11'd1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 11'd2, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_instr", 32'(write_Instruction), 32'd0);
    check("rst_ready", 32'(write_Ready), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      load_en = tbl[i].en;
      par_bad = 1'b0;
      if (tbl[i].dlv) exp_q.push_back(tbl[i].d);
      send_frame(tbl[i].d, tbl[i].stop);
      if (!tbl[i].b2b) settle(tbl[i].cnt, tbl[i].fe, tbl[i].done);
    end
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    settle(11'd2, 1'b1, 1'b0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    settle(11'd3, 1'b1, 1'b0);
    do_reset();
    load_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'(k * 17 + 3));
      send_frame(8'(k * 17 + 3), 1'b1);
    end
    settle(11'd4, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_instr", 32'(write_Instruction), 32'd0);
    check("arst_ready", 32'(write_Ready), 32'd0);
    check("arst_write", 32'(write), 32'd0);
    check("arst_count", 32'(byte_count), 32'd0);
    check("arst_done", 32'(load_done), 32'd0);
    check("arst_ferr", 32'(frame_error), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    settle(11'd0, 1'b0, 1'b0);
`ifdef PARITY_EN
    do_reset();
    par_bad = 1'b1;
    m_pe = 1'b1;
    send_frame(8'h07, 1'b1);
    settle(11'd0, 1'b0, 1'b0);
    par_bad = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    settle(11'd1, 1'b0, 1'b0);
`endif
    for (int r = 0; r < 5; r++) begin
      do_reset();
      m_cnt = 0;
      m_fe = 1'b0;
      for (int k = 0; k < 8; k++) begin
        d = 8'($urandom);
        st = $urandom_range(0, 5) != 0;
        en = $urandom_range(0, 3) != 0;
        par_bad = PAR && ($urandom_range(0, 3) == 0);
        load_en = en;
        if (st && en && m_cnt < MAXB && !par_bad) begin
          exp_q.push_back(d);
          m_cnt++;
        end
        if (!st) m_fe = 1'b1;
        if (par_bad) m_pe = 1'b1;
        send_frame(d, st);
        repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
        settle(11'(m_cnt), m_fe, m_cnt == MAXB);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
